// File: rtl/sm_conv_pkg.sv
// Shared types and helpers for the bit-serial sign-magnitude to two's-complement converter.
package sm_conv_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } sm_state_t;

   function automatic int cnt_w(input int width);
      return $clog2(width);
   endfunction

endpackage

// File: rtl/sm_to_twos_serial_if.sv
// Valid/ready handshake bundle: magnitude/sign in, two's-complement result out.
interface sm_to_twos_serial_if #(
   parameter int WIDTH = 8
) ();

   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] in_mag;
   logic             in_sign;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] out_data;
   logic             out_ovf;

   modport master (
      output in_valid, in_mag, in_sign, out_ready,
      input  in_ready, out_valid, out_data, out_ovf
   );

   modport slave (
      input  in_valid, in_mag, in_sign, out_ready,
      output in_ready, out_valid, out_data, out_ovf
   );

endinterface

// File: rtl/sm_to_twos_serial_cell.sv
// One serial complement slice: copy bits until the first 1 has been seen, then invert.
module twos_serial_cell (
   input  logic b,
   input  logic f,
   input  logic sign,
   output logic r,
   output logic f_next
);

   assign r      = sign ? (b ^ f) : b;
   assign f_next = f | b;

endmodule

// File: rtl/sm_to_twos_serial.sv
// Bit-serial sign-magnitude to two's-complement converter, LSB first, one bit per clock.
//
// state | meaning
// IDLE  | in_ready high, waiting for an operand
// SHIFT | converting mag[cnt], result shifted in from the MSB side
// DONE  | out_valid high, result and ovf held until out_ready
module sm_to_twos_serial
   import sm_conv_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic                  clk,
   input  logic                  rst,
   sm_to_twos_serial_if.slave    s,
   output logic                  busy
);

   localparam int CW = cnt_w(WIDTH);
   localparam logic [CW-1:0]    LAST     = CW'(WIDTH - 1);
   localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

   sm_state_t        state;
   logic [CW-1:0]    cnt;
   logic [WIDTH-1:0] mag_q;
   logic             sign_q;
   logic             f;
   logic             r;
   logic             f_next;
   logic             ovf;

   twos_serial_cell u_cell (
      .b      (mag_q[cnt]),
      .f      (f),
      .sign   (sign_q),
      .r      (r),
      .f_next (f_next)
   );

   // Negative operands may reach exactly the most-negative value; positives must keep the MSB clear.
   assign ovf = sign_q ? (mag_q > MOST_NEG) : mag_q[WIDTH-1];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= IDLE;
         s.in_ready  <= 1'b1;
         s.out_valid <= 1'b0;
         s.out_data  <= '0;
         s.out_ovf   <= 1'b0;
         busy        <= 1'b0;
         cnt         <= '0;
         f           <= 1'b0;
         mag_q       <= '0;
         sign_q      <= 1'b0;
      end else begin
         unique case (state)
            IDLE: begin
               if (s.in_valid) begin
                  mag_q      <= s.in_mag;
                  sign_q     <= s.in_sign;
                  f          <= 1'b0;
                  cnt        <= '0;
                  s.in_ready <= 1'b0;
                  busy       <= 1'b1;
                  state      <= SHIFT;
               end
            end
            SHIFT: begin
               s.out_data <= {r, s.out_data[WIDTH-1:1]};
               f          <= f_next;
               cnt        <= cnt + 1'b1;
               if (cnt == LAST) begin
                  s.out_ovf   <= ovf;
                  s.out_valid <= 1'b1;
                  busy        <= 1'b0;
                  state       <= DONE;
               end
            end
            DONE: begin
               if (s.out_ready) begin
                  s.out_valid <= 1'b0;
                  s.in_ready  <= 1'b1;
                  state       <= IDLE;
               end
            end
            default: begin
               s.out_valid <= 1'b0;
               s.in_ready  <= 1'b1;
               busy        <= 1'b0;
               state       <= IDLE;
            end
         endcase
      end
   end

endmodule
